// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic-light controller and its sensor front end.
package traffic_pkg;

  localparam logic [2:0] LIGHT_R = 3'b100;
  localparam logic [2:0] LIGHT_Y = 3'b010;
  localparam logic [2:0] LIGHT_G = 3'b001;

  typedef enum logic [3:0] {
    S0  = 4'd0,
    S1  = 4'd1,
    S2  = 4'd2,
    S3  = 4'd3,
    S4  = 4'd4,
    S5  = 4'd5,
    S6  = 4'd6,
    S7  = 4'd7,
    S8  = 4'd8,
    S9  = 4'd9,
    S10 = 4'd10,
    S11 = 4'd11,
    S12 = 4'd12
  } ctrl_state_e;

  // Anything other than exactly the G code counts as not green.
  function automatic logic is_green(input logic [2:0] light);
    return light == LIGHT_G;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// One detector channel: two-flop synchronizer, stability debouncer and a
// registered one-cycle pulse on each accepted rising edge.
module sensor_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db,
  output logic rise
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             db_q, db_d;
  logic             db_dly_q;
  logic             rise_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any sample matching the accepted level restarts the stability count.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (s2_q != db_q) begin
      if (cnt_q == CntMax) begin
        db_d = s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      db_q     <= 1'b0;
      cnt_q    <= '0;
      db_dly_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      db_q     <= db_d;
      cnt_q    <= cnt_d;
      db_dly_q <= db_q;
      rise_q   <= db_q & ~db_dly_q;
    end
  end

  assign db   = db_q;
  assign rise = rise_q;

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Conditions raw street detectors into controller demands Sa/Sb.
// Define SENSOR_LATCH_EN to hold demand until the street is served green.
module traffic_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw_a,
  input  logic       raw_b,
  input  logic [2:0] lightA,
  input  logic [2:0] lightB,
  output logic       Sa,
  output logic       Sb,
  output logic       arrive_a,
  output logic       arrive_b
);

  logic db_a, db_b;

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_deb_a (
    .clk (clk),
    .rst (rst),
    .raw (raw_a),
    .db  (db_a),
    .rise(arrive_a)
  );

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_deb_b (
    .clk (clk),
    .rst (rst),
    .raw (raw_b),
    .db  (db_b),
    .rise(arrive_b)
  );

`ifdef SENSOR_LATCH_EN
  logic [2:0] la_q, lb_q;
  logic       req_a_q, req_a_d;
  logic       req_b_q, req_b_d;

  // Serving green wins over a new arrival, so a car waiting at green never latches.
  always_comb begin
    req_a_d = req_a_q;
    req_b_d = req_b_q;
    if (is_green(la_q)) begin
      req_a_d = 1'b0;
    end else if (db_a) begin
      req_a_d = 1'b1;
    end
    if (is_green(lb_q)) begin
      req_b_d = 1'b0;
    end else if (db_b) begin
      req_b_d = 1'b1;
    end
  end

  // Lights already run off this clock, so one register stage is enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      la_q    <= '0;
      lb_q    <= '0;
      req_a_q <= 1'b0;
      req_b_q <= 1'b0;
    end else begin
      la_q    <= lightA;
      lb_q    <= lightB;
      req_a_q <= req_a_d;
      req_b_q <= req_b_d;
    end
  end

  assign Sa = db_a | req_a_q;
  assign Sb = db_b | req_b_q;
`else
  logic unused_lights;
  assign unused_lights = ^{lightA, lightB};

  assign Sa = db_a;
  assign Sb = db_b;
`endif

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Self-checking bench for traffic_sensor_conditioner with DEBOUNCE_CYCLES=4.
`timescale 1ns/1ps
module tb_traffic_sensor_conditioner;
  import traffic_pkg::*;

  localparam int D = 4;
`ifdef SENSOR_LATCH_EN
  localparam bit LatchEn = 1'b1;
`else
  localparam bit LatchEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, raw_a, raw_b;
  logic [2:0] lightA, lightB;
  logic       Sa, Sb, arrive_a, arrive_b;
  int         total = 0;
  int         bad   = 0;

  traffic_sensor_conditioner #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .raw_a   (raw_a),
    .raw_b   (raw_b),
    .lightA  (lightA),
    .lightB  (lightB),
    .Sa      (Sa),
    .Sb      (Sb),
    .arrive_a(arrive_a),
    .arrive_b(arrive_b)
  );

  always #5 clk = ~clk;

  // Reference model: a level is accepted once the last D synchronized samples
  // (taken 2..D+1 edges ago) all disagree with the accepted level.
  bit m_hist [2][D+1];
  bit m_db [2], m_req [2], m_rose [2], m_arr [2], m_green [2];

  always @(posedge clk) begin
    bit         raw_now [2];
    logic [2:0] lt [2];
    raw_now[0] = raw_a;
    raw_now[1] = raw_b;
    lt[0]      = lightA;
    lt[1]      = lightB;
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        for (int i = 0; i <= D; i++) m_hist[c][i] = 1'b0;
        m_db[c]    = 1'b0;
        m_req[c]   = 1'b0;
        m_rose[c]  = 1'b0;
        m_arr[c]   = 1'b0;
        m_green[c] = 1'b0;
      end else begin
        bit flip, old_db, old_green;
        flip = 1'b1;
        for (int i = 1; i <= D; i++) if (m_hist[c][i] == m_db[c]) flip = 1'b0;
        old_db    = m_db[c];
        old_green = m_green[c];
        if (flip) m_db[c] = ~m_db[c];
        m_arr[c]  = m_rose[c];
        m_rose[c] = !old_db && m_db[c];
        if (old_green) m_req[c] = 1'b0;
        else if (old_db) m_req[c] = 1'b1;
        m_green[c] = (lt[c] == LIGHT_G);
        for (int i = D; i >= 1; i--) m_hist[c][i] = m_hist[c][i-1];
        m_hist[c][0] = raw_now[c];
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clean();
    raw_a = 1'b0;
    raw_b = 1'b0;
    lightA = LIGHT_R;
    lightB = LIGHT_R;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    raw_a = 1'b1;
    raw_b = 1'b1;
    lightA = LIGHT_R;
    lightB = LIGHT_R;
    tick(2);
    for (int e = 0; e < 8; e++) begin
      total++;
      if ({Sa, Sb, arrive_a, arrive_b} !== 4'b0000) begin
        bad++;
        $display("FAIL reset_hold cyc %0d: got %b%b%b%b want 0000", e, Sa, Sb, arrive_a, arrive_b);
      end
      tick(1);
    end
    rst = 1'b0;
    raw_a = 1'b0;
    raw_b = 1'b0;
  endtask

  task automatic test_rise();
    clean();
    raw_b = 1'b1;
    for (int e = 0; e < 9; e++) begin
      tick(1);
      total++;
      if (Sb !== (e >= 5)) begin
        bad++;
        $display("FAIL rise_sb edge k+%0d: got %b want %b", e, Sb, (e >= 5));
      end
      total++;
      if (arrive_b !== (e == 6)) begin
        bad++;
        $display("FAIL rise_arrive_b edge k+%0d: got %b want %b", e, arrive_b, (e == 6));
      end
    end
  endtask

  task automatic test_glitch();
    clean();
    raw_a = 1'b1;
    tick(3);
    raw_a = 1'b0;
    for (int e = 3; e < 14; e++) begin
      tick(1);
      total++;
      if ({Sa, arrive_a} !== 2'b00) begin
        bad++;
        $display("FAIL glitch edge k+%0d: got Sa=%b arrive_a=%b want 0 0", e, Sa, arrive_a);
      end
    end
    // A pulse exactly D samples long is accepted.
    clean();
    raw_a = 1'b1;
    tick(4);
    raw_a = 1'b0;
    for (int e = 4; e < 12; e++) begin
      logic exp_sa;
      tick(1);
      exp_sa = (e >= 5 && e < 9) ? 1'b1 : ((e >= 9) ? LatchEn : 1'b0);
      total++;
      if (Sa !== exp_sa || arrive_a !== (e == 6)) begin
        bad++;
        $display("FAIL exact_d edge k+%0d: got Sa=%b arrive_a=%b want %b %b", e, Sa, arrive_a,
                 exp_sa, (e == 6));
      end
    end
  endtask

  task automatic test_latch();
    clean();
    raw_b = 1'b1;
    tick(8);
    total++;
    if (Sb !== 1'b1) begin
      bad++;
      $display("FAIL latch_set: got %b want 1", Sb);
    end
    raw_b = 1'b0;
    for (int e = 0; e < 8; e++) begin
      logic exp_sb;
      tick(1);
      exp_sb = (e < 5) ? 1'b1 : LatchEn;
      total++;
      if (Sb !== exp_sb) begin
        bad++;
        $display("FAIL latch_hold edge k+%0d: got %b want %b", e, Sb, exp_sb);
      end
    end
    lightB = LIGHT_G;
    tick(1);
    total++;
    if (Sb !== LatchEn) begin
      bad++;
      $display("FAIL latch_green_j: got %b want %b", Sb, LatchEn);
    end
    tick(1);
    total++;
    if (Sb !== 1'b0) begin
      bad++;
      $display("FAIL latch_clear_j1: got %b want 0", Sb);
    end
    lightB = LIGHT_R;
    tick(3);
    total++;
    if (Sb !== 1'b0) begin
      bad++;
      $display("FAIL latch_stays_clear: got %b want 0", Sb);
    end
  endtask

  task automatic test_green_waiting();
    clean();
    lightA = LIGHT_G;
    raw_a = 1'b1;
    tick(8);
    total++;
    if (Sa !== 1'b1) begin
      bad++;
      $display("FAIL green_wait_sa: got %b want 1", Sa);
    end
    raw_a = 1'b0;
    for (int e = 0; e < 8; e++) begin
      tick(1);
      total++;
      if (Sa !== (e < 5)) begin
        bad++;
        $display("FAIL green_drop edge k+%0d: got %b want %b", e, Sa, (e < 5));
      end
    end
    lightA = LIGHT_R;
    tick(3);
    total++;
    if (Sa !== 1'b0) begin
      bad++;
      $display("FAIL green_no_latch: got %b want 0", Sa);
    end
  endtask

  task automatic test_reset_mid();
    clean();
    raw_b = 1'b1;
    tick(8);
    raw_b = 1'b0;
    tick(6);
    total++;
    if (Sb !== LatchEn) begin
      bad++;
      $display("FAIL mid_req_b: got %b want %b", Sb, LatchEn);
    end
    raw_a = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(1);
    total++;
    if ({Sa, Sb, arrive_a, arrive_b} !== 4'b0000) begin
      bad++;
      $display("FAIL mid_reset: got %b%b%b%b want 0000", Sa, Sb, arrive_a, arrive_b);
    end
    rst = 1'b0;
    for (int e = 1; e < 9; e++) begin
      tick(1);
      total++;
      if (Sa !== (e >= 6) || arrive_a !== (e == 7) || Sb !== 1'b0) begin
        bad++;
        $display("FAIL mid_restart edge r+%0d: got Sa=%b arrive_a=%b Sb=%b want %b %b 0", e, Sa,
                 arrive_a, Sb, (e >= 6), (e == 7));
      end
    end
  endtask

  task automatic test_random();
    int         run_a, run_b, run_l;
    logic [2:0] picks [6];
    logic       exp_sa, exp_sb;
    picks = '{LIGHT_R, LIGHT_Y, LIGHT_G, LIGHT_G, 3'b011, 3'b000};
    clean();
    run_a = 1;
    run_b = 1;
    run_l = 1;
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 249) == 0);
      if (--run_a == 0) begin
        raw_a = ~raw_a;
        run_a = $urandom_range(1, 8);
      end
      if (--run_b == 0) begin
        raw_b = ~raw_b;
        run_b = $urandom_range(1, 8);
      end
      if (--run_l == 0) begin
        lightA = picks[$urandom_range(0, 5)];
        lightB = picks[$urandom_range(0, 5)];
        run_l = $urandom_range(3, 20);
      end
      tick(1);
      exp_sa = m_db[0] | (LatchEn & m_req[0]);
      exp_sb = m_db[1] | (LatchEn & m_req[1]);
      total++;
      if ({Sa, Sb, arrive_a, arrive_b} !== {exp_sa, exp_sb, m_arr[0], m_arr[1]}) begin
        bad++;
        $display("FAIL random cyc %0d: got Sa,Sb,arr_a,arr_b=%b%b%b%b want %b%b%b%b", n, Sa, Sb,
                 arrive_a, arrive_b, exp_sa, exp_sb, m_arr[0], m_arr[1]);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_latch();
    test_green_waiting();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_sensor_conditioner.md
# traffic_sensor_conditioner

Conditions the two raw vehicle-detector inputs for `traffic_light_controller`, producing its `Sa`/`Sb` inputs. Each channel is synchronized, debounced and, optionally, latched as a pending request until that street is served with green. Sits directly upstream of the controller. Runs on the board clock and watches the controller's light outputs to clear served requests.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable `clk` cycles required to accept a level change (≥1; 10 ms at 100 MHz).
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)+1`: debounce counter width.

- `clk`  in  1  board clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `raw_a`  in  1  street-A detector, asynchronous, active-high.
- `raw_b`  in  1  street-B detector, asynchronous, active-high.
- `lightA`  in  3  controller light A, one-hot {R,Y,G}, G=3'b001.
- `lightB`  in  3  controller light B, same encoding.
- `Sa`  out  1  conditioned street-A demand, to controller.
- `Sb`  out  1  conditioned street-B demand, to controller.
- `arrive_a`  out  1  one-cycle pulse on debounced A rising edge.
- `arrive_b`  out  1  one-cycle pulse on debounced B rising edge.

## Operation
Per channel x ∈ {a,b}, independent and identical:
- Synchronizer: `s1 <= raw_x; s2 <= s1`.
- Debouncer: stable register `db_x` and counter `cnt`.
  - `s2 == db_x`: `cnt <= 0`.
  - `s2 != db_x` and `cnt == DEBOUNCE_CYCLES-1`: `db_x <= s2`, `cnt <= 0`.
  - Otherwise: `cnt <= cnt+1`.
  - A glitch shorter than DEBOUNCE_CYCLES consecutive cycles never reaches `db_x`. Any return to the old level restarts the count.
- `arrive_x` is high for exactly one cycle, in the cycle after `db_x` goes 0→1. The pulse is registered. A falling edge produces no pulse.
- Green detect: `lightX` is registered once into `lx_q`. The street counts as green only when `lx_q == 3'b001`. Non-one-hot values count as not green.
- Request latch `req_x`, compiled in by `SENSOR_LATCH_EN`:
  - Clear: if `lx_q` is green, `req_x <= 0`.
  - Set: else if `db_x`, `req_x <= 1`.
  - Clear has priority over set. A car waiting at a green street is never latched.
- Output: `Sx = db_x | req_x`.

Reset (`rst` high at a `clk` edge) clears `s1`, `s2`, `db_x`, `cnt`, `req_x`, `lx_q` and the pulse registers. All outputs read 0 from the cycle after that edge and stay 0 while `rst` is held. Reset mid-debounce discards the partial count. Reset mid-request drops the pending request.

## Timing
- Raw edge sampled by `s1` at edge k: `db_x` updates at edge k+1+DEBOUNCE_CYCLES. `Sx` rises in the same cycle as `db_x`.
- `arrive_x` is asserted for the single cycle after edge k+2+DEBOUNCE_CYCLES.
- Light inputs add one cycle: `lightX` turns G at edge j, and `req_x` clears at edge j+1.
- `lightA`/`lightB` change only on `clk_1Hz` edges, which derive from `clk`. The lights are therefore synchronous to `clk` and need no synchronizer.
- Simultaneous activity on both channels is fully independent. No arbitration is needed.

## Configuration
- `SENSOR_LATCH_EN` defined: the request latch is present, and `Sx = db_x | req_x`. A car that leaves before being served keeps demand asserted until its street shows green.
- `SENSOR_LATCH_EN` undefined: no latch and no light-input logic. `Sx = db_x`, and `lightA`/`lightB` are unused. The ports remain on the module.

## Structure
- Package `traffic_pkg` holds:
  - light encodings `LIGHT_R=3'b100`, `LIGHT_Y=3'b010`, `LIGHT_G=3'b001`;
  - the 4-bit controller state codes S0–S12.
- Sub-module `sensor_debounce`:
  - Parameters: `DEBOUNCE_CYCLES`, `CNT_W`.
  - Ports: `clk`, `rst`, `raw`, `db`, `rise`.
  - Contains the synchronizer, debouncer and rise pulse.
  - Instantiated twice.
- The top level holds the light registers, the request latches and the output ORs.

## Test plan
Bench runs with `DEBOUNCE_CYCLES=4`, `SENSOR_LATCH_EN` defined unless noted.
- `raw_b` 0→1 held, sampled at edge k, `lightB=R` → `Sb` rises at edge k+5; `arrive_b` is high only in the cycle after edge k+6.
- `raw_a` pulses high for 3 cycles, then low → `Sa` and `arrive_a` stay 0 throughout.
- `raw_b` high long enough to set `Sb`, then low, `lightB=R` → `Sb` stays 1. Drive `lightB=G` at edge j → `Sb` falls at edge j+1.
- `lightA=G` while `raw_a` is held high → `Sa=1` via `db_a`, `req_a` stays 0. Drop `raw_a` → `Sa` falls at edge k+5, with no latched demand.
- Assert `rst` for 1 cycle while `req_b=1` and the A debounce count is at 2 → all outputs 0 next cycle. `raw_a` still high → `Sa` rises 6 edges after reset release (the first sync edge counts as k).
- `SENSOR_LATCH_EN` undefined: repeat scenario 3 → `Sb` falls at edge k+5 after `raw_b` drops, regardless of `lightB`.
